// File: rtl/add_shft_mul_pkg.sv
// Shared definitions for the sequential multiplier and its divider companion:
// control state encoding, counter sizing and operand magnitude.
package add_shft_mul_pkg;

  typedef enum logic [1:0] {
    ST_DONE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Widest operand mag() can handle; callers zero-extend into this width.
  localparam int MAG_MAX_W = 64;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // |x| of a w-bit value as w-bit unsigned; the most-negative value maps to
  // 2^(w-1) because the result is read as unsigned.
  function automatic logic [MAG_MAX_W-1:0] mag(input logic [MAG_MAX_W-1:0] x,
                                               input int                   w,
                                               input logic                 signed_en);
    logic [MAG_MAX_W-1:0] mask;
    logic [MAG_MAX_W-1:0] neg_x;
    logic                 msb;
    mask  = {MAG_MAX_W{1'b1}} >> (MAG_MAX_W - w);
    neg_x = (~x + 64'd1) & mask;
    msb   = ((x >> (w - 1)) & 64'd1) != 64'd0;
    if (signed_en && msb) return neg_x;
    return x & mask;
  endfunction

endpackage

// File: rtl/add_shft_mul_if.sv
// Start/done operand bus shared by the sequential multiplier and divider.
interface add_shft_mul_if #(
  parameter int W = 8
);
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           start;
  logic [2*W-1:0] p;
  logic           done;

  modport master (output a, output b, output start, input p, input done);
  modport slave  (input a, input b, input start, output p, output done);
endinterface

// File: rtl/add_shft_mul.sv
// Sequential MSB-first shift-and-add multiplier, one partial product per clock,
// with optional two's complement mode via sign-magnitude and a final negate.
module add_shft_mul
  import add_shft_mul_pkg::*;
#(
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input logic           clk,
  input logic           rst,
  add_shft_mul_if.slave bus
);

  localparam int            PW   = 2 * W;
  localparam int            CW   = clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_n;
  logic [PW-1:0] p_q, p_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  ar, ar_n;
  logic [W-1:0]  br, br_n;
  logic          neg, neg_n;
  logic [W-1:0]  ar_sh;
  logic [PW-1:0] addend;

  function automatic logic [W-1:0] mag_w(input logic [W-1:0] x);
    logic [MAG_MAX_W-1:0] wide;
    wide = MAG_MAX_W'(x);
    wide = mag(wide, W, SIGNED != 0);
    return wide[W-1:0];
  endfunction

  function automatic logic [PW-1:0] negate(input logic [PW-1:0] x);
    return ~x + PW'(1);
  endfunction

  always_comb begin
    state_n = state;
    p_n     = p_q;
    cnt_n   = cnt;
    ar_n    = ar;
    br_n    = br;
    neg_n   = neg;
    // Multiplier bit for this iteration sits at ar[W-1-cnt].
    ar_sh   = ar << cnt;
    addend  = ar_sh[W-1] ? {{W{1'b0}}, br} : '0;

    if (bus.start) begin
      ar_n    = mag_w(bus.a);
      br_n    = mag_w(bus.b);
      neg_n   = (SIGNED != 0) & (bus.a[W-1] ^ bus.b[W-1]);
      p_n     = '0;
      cnt_n   = '0;
      state_n = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          p_n   = (p_q << 1) + addend;
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) state_n = ST_FIX;
        end
        ST_FIX: begin
          if (neg) p_n = negate(p_q);
          state_n = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DONE;
      p_q   <= '0;
      cnt   <= '0;
      ar    <= '0;
      br    <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_n;
      p_q   <= p_n;
      cnt   <= cnt_n;
      ar    <= ar_n;
      br    <= br_n;
      neg   <= neg_n;
    end
  end

  assign bus.p    = p_q;
  assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_add_shft_mul.sv
// Directed and swept checks of the unsigned and signed multiplier variants.
module tb_add_shft_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_shft_mul_if #(.W(8)) bus0 ();
  add_shft_mul_if #(.W(8)) bus1 ();

  add_shft_mul #(.W(8), .SIGNED(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  add_shft_mul #(.W(8), .SIGNED(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge (E0).
  task automatic launch(input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1);
    bus0.a = a0; bus0.b = b0; bus0.start = 1'b1;
    bus1.a = a1; bus1.b = b1; bus1.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  // Counts rising edges after E0 until each done rises; -1 if the bound expires.
  task automatic wait_done(output int lat0, output int lat1);
    int n;
    n = 0; lat0 = -1; lat1 = -1;
    while ((lat0 < 0 || lat1 < 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (bus0.done && lat0 < 0) lat0 = n;
      if (bus1.done && lat1 < 0) lat1 = n;
    end
  endtask

  task automatic op(input logic [7:0] a0, input logic [7:0] b0,
                    input logic [7:0] a1, input logic [7:0] b1,
                    output logic d0, output logic d1,
                    output int lat0, output int lat1,
                    output logic [15:0] p0, output logic [15:0] p1);
    launch(a0, b0, a1, b1);
    d0 = bus0.done;
    d1 = bus1.done;
    wait_done(lat0, lat1);
    p0 = bus0.p;
    p1 = bus1.p;
  endtask

  logic [7:0]  ua [3] = '{8'd255, 8'd0,   8'd1};
  logic [7:0]  ub [3] = '{8'd255, 8'd200, 8'd255};
  logic [15:0] up [3] = '{16'hFE01, 16'h0000, 16'h00FF};
  logic [7:0]  sa [4] = '{8'h80, 8'h80, 8'hFB, 8'h00};
  logic [7:0]  sb [4] = '{8'h80, 8'h7F, 8'h07, 8'hFF};
  logic [15:0] sp [4] = '{16'h4000, 16'hC080, 16'hFFDD, 16'h0000};

  initial begin
    logic        d0, d1;
    int          l0, l1;
    logic [15:0] p0, p1;
    logic [7:0]  ra, rb, rc, rd;
    logic [15:0] e0, e1;
    int          sprod;

    rst = 1'b1;
    bus0.a = '0; bus0.b = '0; bus0.start = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done0", bus0.done, 1'b1);
    check("rst_p0",    bus0.p,    16'h0000);
    check("rst_done1", bus1.done, 1'b1);
    check("rst_p1",    bus1.p,    16'h0000);
    rst = 1'b0;
    @(negedge clk);

    op(8'd144, 8'd33, 8'd144, 8'd33, d0, d1, l0, l1, p0, p1);
    check("t1_done_fall", d0, 1'b0);
    check("t1_lat",       l0, 9);
    check("t1_p",         p0, 16'h1290);
    check("t1_lat_s",     l1, 9);
    repeat (3) @(negedge clk);
    check("t1_hold_p",    bus0.p,    16'h1290);
    check("t1_hold_done", bus0.done, 1'b1);

    for (int i = 0; i < 3; i++) begin
      op(ua[i], ub[i], ua[i], ub[i], d0, d1, l0, l1, p0, p1);
      check($sformatf("t2_p_%0d", i),   p0, up[i]);
      check($sformatf("t2_lat_%0d", i), l0, 9);
    end

    for (int i = 0; i < 4; i++) begin
      op(sa[i], sb[i], sa[i], sb[i], d0, d1, l0, l1, p0, p1);
      check($sformatf("t3_p_%0d", i),   p1, sp[i]);
      check($sformatf("t3_lat_%0d", i), l1, 9);
    end

    launch(8'd10, 8'd10, 8'd10, 8'd10);
    repeat (4) @(negedge clk);
    check("t4_mid_done", bus0.done, 1'b0);
    launch(8'd3, 8'd7, 8'd3, 8'd7);
    check("t4_restart_done", bus0.done, 1'b0);
    wait_done(l0, l1);
    check("t4_lat",  l0, 9);
    check("t4_p",    bus0.p, 16'd21);
    check("t4_lat_s", l1, 9);
    check("t4_p_s",  bus1.p, 16'd21);

    launch(8'd200, 8'd200, 8'd200, 8'd200);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_done", bus0.done, 1'b1);
    check("t5_rst_p",    bus0.p,    16'h0000);
    check("t5_rst_p_s",  bus1.p,    16'h0000);
    @(negedge clk);
    check("t5_rst_idle", bus0.done, 1'b1);

    op(8'd6, 8'd7, 8'd6, 8'd7, d0, d1, l0, l1, p0, p1);
    check("t5_pre_p", p0, 16'd42);
    rst = 1'b1;
    bus0.a = 8'd5; bus0.b = 8'd5; bus0.start = 1'b1;
    bus1.a = 8'd5; bus1.b = 8'd5; bus1.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus0.start = 1'b0; bus1.start = 1'b0;
    check("t5_coll_done", bus0.done, 1'b1);
    check("t5_coll_p",    bus0.p,    16'h0000);
    repeat (3) @(negedge clk);
    check("t5_coll_idle_done", bus0.done, 1'b1);
    check("t5_coll_idle_p",    bus0.p,    16'h0000);
    check("t5_coll_idle_p_s",  bus1.p,    16'h0000);

    // Second op launches on the very falling edge where done was first seen.
    op(8'd12, 8'd13, 8'd12, 8'd13, d0, d1, l0, l1, p0, p1);
    check("t6_first_p", p0, 16'd156);
    op(8'd2, 8'd3, 8'd2, 8'd3, d0, d1, l0, l1, p0, p1);
    check("t6_b2b_fall", d0, 1'b0);
    check("t6_b2b_lat",  l0, 9);
    check("t6_b2b_p",    p0, 16'd6);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 8'($urandom); rd = 8'($urandom);
      op(ra, rb, rc, rd, d0, d1, l0, l1, p0, p1);
      e0 = {8'd0, ra} * {8'd0, rb};
      sprod = int'($signed(rc)) * int'($signed(rd));
      e1 = sprod[15:0];
      check("sweep_u", {l0[15:0], p0}, {16'd9, e0});
      check("sweep_s", {l1[15:0], p1}, {16'd9, e1});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
